bin2bcd_disp_feed: RTL and testbench

//  Iterative binary-to-BCD converter (shift-add-3, one bit per clock) feeding the 8-digit

---
 rtl/bin2bcd_disp_feed.sv | 160 ++++++++++++++++
 tb/tb_bin2bcd_disp_feed.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_disp_feed.sv
// bin2bcd_disp_feed
// Iterative binary-to-BCD converter (shift-add-3, one input bit per clock)
// that feeds an 8-digit multiplexed 7-segment driver. It converts an
// unsigned count into 8 BCD nibbles plus a leading-zero blank mask.
// Display-facing outputs are registers that change only in the cycle a
// conversion completes, so the display never shows a partial result.
//
// Handshake: START is a request level sampled only while idle (BUSY=0).
// The edge that samples START=1 in IDLE accepts the request and captures
// DIN. BUSY is high from the cycle after acceptance until the result is
// written. DONE pulses high for exactly one cycle, and HEX_OUT, BLANK_OUT
// and OVF carry the new result in that same cycle. A START seen while BUSY
// is dropped, not queued. START may be held high to convert back to back,
// one result every DIN_W+2 clocks.

module bin2bcd_disp_feed #(
  parameter int DIN_W  = 27,   // legal range 1..27
  parameter bit LZB_EN = 1'b1  // 1: leading-zero blanking, 0: BLANK_OUT = 0
) (
  input  logic             CLK_100,
  input  logic             RST_N,
  input  logic             START,
  input  logic [DIN_W-1:0] DIN,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVF,
  output logic [31:0]      HEX_OUT,
  output logic [7:0]       BLANK_OUT,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // Largest value that fits in eight decimal digits.
  localparam logic [31:0] DEC_MAX   = 32'd99_999_999;
  localparam logic [7:0]  BLANK_RST = LZB_EN ? 8'hFE : 8'h00;
  localparam logic [4:0]  LAST_STEP = 5'(DIN_W - 1);

  state_t             state;
  state_t             state_nxt;

  logic [31:0]        bcd;      // BCD half of the shift register
  logic [DIN_W-1:0]   bin;      // binary half of the shift register
  logic [4:0]         cnt;      // completed conversion steps
  logic               ovf_cap;  // saturation flag for the value in flight

  logic [31:0]        din_ext;
  logic               din_ovf;
  logic [DIN_W-1:0]   din_sat;
  logic [27:0]        low_adj;
  logic [31:0]        bcd_step;
  logic [7:0]         blank_nxt;
  logic               zero_run;

  // Saturate out-of-range input at capture time. For DIN_W < 27, DIN can
  // never exceed DEC_MAX, so the compare folds away.
  assign din_ext = 32'(DIN);
  assign din_ovf = (din_ext > DEC_MAX);
  assign din_sat = din_ovf ? DEC_MAX[DIN_W-1:0] : DIN;

  // Add 3 to each of the low seven nibbles that are >= 5, before the shift.
  // Results never exceed 99_999_999, so the top nibble is at most 4 before
  // any shift and never needs adjusting. The bit that shifts out of it is
  // therefore always 0.
  always_comb begin
    low_adj = '0;
    for (int i = 0; i < 7; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        low_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        low_adj[4*i +: 4] = bcd[4*i +: 4];
      end
    end
  end

  // One conversion step: the adjusted BCD shifts left and takes in the
  // binary MSB.
  assign bcd_step = {bcd[30:28], low_adj, bin[DIN_W-1]};

  // Leading-zero mask: digit i is blanked when digits i..7 are all zero.
  // Digit 0 always shows, so a value of 0 displays "0".
  always_comb begin
    blank_nxt = 8'h00;
    zero_run  = 1'b1;
    if (LZB_EN) begin
      for (int i = 7; i >= 1; i--) begin
        zero_run     = zero_run & (bcd[4*i +: 4] == 4'd0);
        blank_nxt[i] = zero_run;
      end
    end
  end

  // State register.
  always_ff @(posedge CLK_100) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> CONV for DIN_W steps -> LATCH -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (START) state_nxt = ST_CONV;
      ST_CONV:  if (cnt == LAST_STEP) state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture, iterate, then publish the result with a DONE pulse.
  always_ff @(posedge CLK_100) begin
    if (!RST_N) begin
      bcd       <= '0;
      bin       <= '0;
      cnt       <= '0;
      ovf_cap   <= 1'b0;
      DONE      <= 1'b0;
      OVF       <= 1'b0;
      HEX_OUT   <= '0;
      BLANK_OUT <= BLANK_RST;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            bcd     <= '0;
            bin     <= din_sat;
            ovf_cap <= din_ovf;
            cnt     <= '0;
          end
        end
        ST_CONV: begin
          bcd <= bcd_step;
          bin <= bin << 1;
          cnt <= cnt + 5'd1;
        end
        ST_LATCH: begin
          HEX_OUT   <= bcd;
          BLANK_OUT <= blank_nxt;
          OVF       <= ovf_cap;
          DONE      <= 1'b1;
        end
        default: begin
          DONE <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY      = (state == ST_CONV) || (state == ST_LATCH);
  assign dbg_state = state;

endmodule

// File: tb/tb_bin2bcd_disp_feed.sv
// Bench for bin2bcd_disp_feed: two instances (blanking on and off) share
// the same stimulus. A decimal-arithmetic model predicts every output on
// every cycle, and directed vectors pin literal results.

module tb_bin2bcd_disp_feed;

  localparam int DIN_W = 27;
  localparam int LAT   = DIN_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [DIN_W-1:0] din = '0;

  always #5 clk = ~clk;

  logic        busy, done, ovf;
  logic [31:0] hex;
  logic [7:0]  blank;
  logic [1:0]  st;
  logic        busy_nb, done_nb, ovf_nb;
  logic [31:0] hex_nb;
  logic [7:0]  blank_nb;
  logic [1:0]  st_nb;

  bin2bcd_disp_feed #(.DIN_W(DIN_W), .LZB_EN(1'b1)) dut (
    .CLK_100(clk), .RST_N(rst_n), .START(start), .DIN(din),
    .BUSY(busy), .DONE(done), .OVF(ovf), .HEX_OUT(hex),
    .BLANK_OUT(blank), .dbg_state(st)
  );

  bin2bcd_disp_feed #(.DIN_W(DIN_W), .LZB_EN(1'b0)) dut_nb (
    .CLK_100(clk), .RST_N(rst_n), .START(start), .DIN(din),
    .BUSY(busy_nb), .DONE(done_nb), .OVF(ovf_nb), .HEX_OUT(hex_nb),
    .BLANK_OUT(blank_nb), .dbg_state(st_nb)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- model (decimal arithmetic) ----------------
  function automatic logic [31:0] sat_val(input logic [DIN_W-1:0] d);
    if (32'(d) > 32'd99_999_999) return 32'd99_999_999;
    return 32'(d);
  endfunction

  function automatic logic [31:0] to_bcd(input logic [31:0] v_in);
    logic [31:0] h;
    logic [31:0] v;
    h = '0;
    v = v_in;
    for (int i = 0; i < 8; i++) begin
      h[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return h;
  endfunction

  // Digit i blank iff value < 10^i (digits i..7 zero), i = 1..7.
  function automatic logic [7:0] lzb(input logic [31:0] v);
    logic [7:0]  b;
    logic [31:0] p;
    b = 8'h00;
    p = 32'd10;
    for (int i = 1; i < 8; i++) begin
      b[i] = (v < p);
      p = p * 10;
    end
    return b;
  endfunction

  logic        m_valid = 1'b0;
  int          m_left  = 0;   // busy cycles remaining
  logic        m_done  = 1'b0;
  logic        m_ovf   = 1'b0;
  logic [31:0] m_hex   = '0;
  logic [7:0]  m_blank = 8'hFE;
  logic        p_ovf;
  logic [31:0] p_hex;
  logic [7:0]  p_blank;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b1;
      m_left  <= 0;
      m_done  <= 1'b0;
      m_ovf   <= 1'b0;
      m_hex   <= '0;
      m_blank <= 8'hFE;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (start) begin
          p_hex   <= to_bcd(sat_val(din));
          p_blank <= lzb(sat_val(din));
          p_ovf   <= (32'(din) > 32'd99_999_999);
          m_left  <= LAT;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done  <= 1'b1;
          m_hex   <= p_hex;
          m_blank <= p_blank;
          m_ovf   <= p_ovf;
        end
      end
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("cycle",
        {busy, done, ovf, hex, blank, hex_nb, blank_nb, busy_nb, done_nb, ovf_nb},
        {(m_left != 0), m_done, m_ovf, m_hex, m_blank, m_hex, 8'h00,
         (m_left != 0), m_done, m_ovf});
    end
  end

  // ---------------- driver tasks ----------------
  // One-cycle START; returns edges from acceptance to DONE (-1 on timeout).
  task automatic convert(input logic [DIN_W-1:0] d, output int lat);
    @(negedge clk);
    start = 1'b1;
    din   = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    din   = ~d;
    lat   = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic conv_lit(input string name, input logic [DIN_W-1:0] d,
                          input logic [31:0] e_hex, input logic [7:0] e_blank,
                          input logic e_ovf);
    int lat;
    convert(d, lat);
    check({name, "_lat"}, 96'(lat), 96'(LAT));
    check({name, "_hex"}, 96'(hex), 96'(e_hex));
    check({name, "_blank"}, 96'(blank), 96'(e_blank));
    check({name, "_ovf"}, 96'(ovf), 96'(e_ovf));
    check({name, "_model"}, {m_hex, m_blank, m_ovf}, {e_hex, e_blank, e_ovf});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int done_cnt;
    int busy_cnt;
    int t_a;
    int t_b;
    logic [DIN_W-1:0] r;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hex", 96'(hex), 96'h0);
    check("rst_blank", 96'(blank), 96'hFE);
    check("rst_blank_nb", 96'(blank_nb), 96'h00);
    check("rst_flags", {busy, done, ovf}, 96'h0);
    @(negedge clk);
    rst_n = 1'b1;

    conv_lit("zero", 27'd0, 32'h00000000, 8'hFE, 1'b0);
    conv_lit("d12345", 27'd12345, 32'h00012345, 8'hE0, 1'b0);
    conv_lit("d1e7", 27'd10_000_000, 32'h10000000, 8'h00, 1'b0);
    conv_lit("dmax", 27'd99_999_999, 32'h99999999, 8'h00, 1'b0);
    conv_lit("d1e8", 27'd100_000_000, 32'h99999999, 8'h00, 1'b1);
    conv_lit("dall1", 27'd134_217_727, 32'h99999999, 8'h00, 1'b1);
    conv_lit("d7", 27'd7, 32'h00000007, 8'hFE, 1'b0);
    check("d7_nb", {hex_nb, blank_nb}, {32'h00000007, 8'h00});
    conv_lit("d90", 27'd90, 32'h00000090, 8'hFC, 1'b0);

    // START pulses mid-conversion must be ignored.
    @(negedge clk);
    start = 1'b1;
    din   = 27'd4321;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    done_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      start = (n == 5) || (n == 20);
      din   = 27'd55555;
    end
    start = 1'b0;
    check("ign_done_cnt", 96'(done_cnt), 96'd1);
    check("ign_busy_cnt", 96'(busy_cnt), 96'(LAT));
    check("ign_hex", {hex, blank}, {32'h00004321, 8'hF0});

    // START held high: one result every DIN_W+2 clocks.
    @(negedge clk);
    start = 1'b1;
    din   = 27'd2024;
    t_a = -1;
    t_b = -1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (t_a < 0) t_a = n;
        else if (t_b < 0) t_b = n;
      end
    end
    start = 1'b0;
    check("held_period", 96'(t_b - t_a), 96'(DIN_W + 2));
    check("held_hex", 96'(hex), 96'h00002024);
    repeat (35) @(posedge clk);

    // Reset mid-conversion: abort, no DONE, outputs back to reset values.
    @(negedge clk);
    start = 1'b1;
    din   = 27'd777;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("abort_done_cnt", 96'(done_cnt), 96'd0);
    check("abort_out", {busy, ovf, hex, blank}, {1'b0, 1'b0, 32'h0, 8'hFE});
    conv_lit("after_rst", 27'd31_415_926, 32'h31415926, 8'h00, 1'b0);

    // Sweep: mix of full-range and small values, checked by the model.
    for (int i = 0; i < 600; i++) begin
      case (i % 4)
        0:       r = 27'($urandom_range(0, 999));
        1:       r = 27'($urandom_range(99_999_000, 100_000_100));
        default: r = 27'($urandom_range(0, 134_217_727));
      endcase
      convert(r, lat);
      check("sweep_lat", 96'(lat), 96'(LAT));
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
